// File: rtl/dso_clk_rst_seq_if.sv
// ---------------------------------------------------------------------------
// dso_clk_rst_seq_if
// Bundles the PLL handshake and the staged reset outputs of the DSO clock/reset
// sequencer.
//   pll_locked     PLL lock indication, asynchronous to the sequencer clock
//   pll_areset     reset request to the clock generator, active high
//   rst_core       control/interface-logic reset, active high
//   rst_sample     sample-path reset, active high
//   ready          high only while the sequencer is in RUN
//   lock_timeout   one-cycle pulse when a lock wait times out
//   lock_loss_cnt  saturating count of lock losses after reset release
// Modports: master = the sequencer, slave = PLL side / downstream consumers.
// ---------------------------------------------------------------------------
interface dso_clk_rst_seq_if;
    logic       pll_locked;
    logic       pll_areset;
    logic       rst_core;
    logic       rst_sample;
    logic       ready;
    logic       lock_timeout;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked,
        output pll_areset, rst_core, rst_sample, ready, lock_timeout, lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        input  pll_areset, rst_core, rst_sample, ready, lock_timeout, lock_loss_cnt
    );
endinterface

// File: rtl/dso_clk_rst_seq.sv
// ---------------------------------------------------------------------------
// dso_clk_rst_seq
// Reset sequencer sitting directly downstream of the DSO main clock generator.
// It pulses the generator's areset, waits for a stable lock and then releases
// rst_core followed STAGE_GAP cycles later by rst_sample. Any lock loss after
// release re-arms the whole sequence. Runs on the free-running reference clock.
//
// Ports
//   inclk0   in  reference clock, rising edge
//   areset   in  asynchronous active-high reset
//   seq      dso_clk_rst_seq_if.master (pll_locked in, reset/status outputs)
//
// Build option
//   DSO_LOCK_LOSS_CNT_EN  when defined, seq.lock_loss_cnt is an 8-bit
//                         saturating count of lock losses in RELEASE/RUN;
//                         otherwise it reads constant zero.
// ---------------------------------------------------------------------------
module dso_clk_rst_seq #(
    parameter int unsigned PLL_RST_CYC     = 16,
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned STAGE_GAP       = 8,
    parameter int unsigned CNT_W           = 17
) (
    input  logic               inclk0,
    input  logic               areset,
    dso_clk_rst_seq_if.master  seq
);

    // Terminal timer values: a state lasting N cycles leaves when timer == N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             lk_meta_reg, lk_s_reg;
    logic             timeout_hit;

    logic             pll_areset_reg;
    logic             rst_core_reg;
    logic             rst_sample_reg;
    logic             ready_reg;
    logic             lock_timeout_reg;

    // Two-flop synchronizer; nothing downstream looks at pll_locked directly.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            lk_meta_reg <= 1'b0;
            lk_s_reg    <= 1'b0;
        end else begin
            lk_meta_reg <= seq.pll_locked;
            lk_s_reg    <= lk_meta_reg;
        end
    end

    // Lock status is tested before the timer everywhere, which gives lock loss
    // priority in STABLE/RELEASE/RUN and lock rise priority in WAIT_LOCK.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg + CNT_W'(1);
        timeout_hit = 1'b0;
        case (state_reg)
            S_RESET_PLL: begin
                if (timer_reg == PLL_RST_LAST)
                    state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk_s_reg) begin
                    state_next = S_STABLE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next  = S_RESET_PLL;
                    timeout_hit = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lk_s_reg)
                    state_next = S_WAIT_LOCK;
                else if (timer_reg == STABLE_LAST)
                    state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!lk_s_reg)
                    state_next = S_RESET_PLL;
                else if (timer_reg == GAP_LAST)
                    state_next = S_RUN;
            end
            S_RUN: begin
                timer_next = timer_reg;
                if (!lk_s_reg)
                    state_next = S_RESET_PLL;
            end
            default: state_next = S_RESET_PLL;
        endcase
        if (state_next != state_reg)
            timer_next = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state itself and come straight out of flops.
    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset) begin
            state_reg        <= S_RESET_PLL;
            timer_reg        <= '0;
            pll_areset_reg   <= 1'b1;
            rst_core_reg     <= 1'b1;
            rst_sample_reg   <= 1'b1;
            ready_reg        <= 1'b0;
            lock_timeout_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            pll_areset_reg   <= (state_next == S_RESET_PLL);
            rst_core_reg     <= (state_next == S_RESET_PLL) || (state_next == S_WAIT_LOCK) ||
                                (state_next == S_STABLE);
            rst_sample_reg   <= (state_next != S_RUN);
            ready_reg        <= (state_next == S_RUN);
            lock_timeout_reg <= timeout_hit;
        end
    end

    assign seq.pll_areset   = pll_areset_reg;
    assign seq.rst_core     = rst_core_reg;
    assign seq.rst_sample   = rst_sample_reg;
    assign seq.ready        = ready_reg;
    assign seq.lock_timeout = lock_timeout_reg;

`ifdef DSO_LOCK_LOSS_CNT_EN
    logic       loss_hit;
    logic [7:0] loss_cnt_reg;

    // A loss only counts once resets have started to come off.
    assign loss_hit = ((state_reg == S_RELEASE) || (state_reg == S_RUN)) && !lk_s_reg;

    always_ff @(posedge inclk0 or posedge areset) begin
        if (areset)
            loss_cnt_reg <= 8'd0;
        else if (loss_hit && (loss_cnt_reg != 8'hFF))
            loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end

    assign seq.lock_loss_cnt = loss_cnt_reg;
`else
    assign seq.lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dso_clk_rst_seq.sv
module tb_dso_clk_rst_seq;

    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int LTO  = 32;
    localparam int SG   = 3;
    localparam int SYNC = 2;

`ifdef DSO_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int SEL_PA  = 0;
    localparam int SEL_RC  = 1;
    localparam int SEL_RS  = 2;
    localparam int SEL_RDY = 3;
    localparam int SEL_LT  = 4;

    logic inclk0 = 1'b0;
    logic areset = 1'b1;

    dso_clk_rst_seq_if bus ();

    dso_clk_rst_seq #(
        .PLL_RST_CYC    (PRC),
        .LOCK_STABLE_CYC(LSC),
        .LOCK_TIMEOUT   (LTO),
        .STAGE_GAP      (SG),
        .CNT_W          (17)
    ) dut (
        .inclk0(inclk0),
        .areset(areset),
        .seq   (bus.master)
    );

    always #5 inclk0 = ~inclk0;

    int n_cmp = 0;
    int n_bad = 0;
    int timeouts_seen = 0;
    int pa_seen = 0;
    int losses = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected saturating loss count as seen from outside.
    function automatic logic [31:0] exp_cnt();
        if (!CNT_EN) return 0;
        return (losses > 255) ? 255 : losses;
    endfunction

    // Cycles from setting pll_locked (t cycles after pll_areset falls) to
    // rst_core falling. WAIT_LOCK occupies evaluation edges 1..LTO, then a
    // PLL retry occupies LTO+1..LTO+PRC, after which WAIT_LOCK resumes.
    function automatic int lock_fall_delay(input int t);
        int first_eval;
        int d;
        first_eval = t + SYNC + 1;
        if (first_eval <= LTO)            d = first_eval;
        else if (first_eval <= LTO + PRC) d = LTO + PRC + 1;
        else                              d = first_eval;
        return d + LSC - t;
    endfunction

    // One clock; sample 1 time unit after the edge and check the output
    // ordering rules that must hold on every cycle.
    task automatic tick();
        logic ok;
        @(posedge inclk0);
        #1;
        if (bus.lock_timeout === 1'b1) timeouts_seen++;
        if (bus.pll_areset === 1'b1) pa_seen++;
        ok = (bus.ready === ~bus.rst_sample) &&
             !(bus.rst_core === 1'b1 && bus.rst_sample !== 1'b1) &&
             !(bus.pll_areset === 1'b1 && bus.rst_core !== 1'b1);
        check("order", {31'd0, ok}, 32'd1);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_PA:  return bus.pll_areset;
            SEL_RC:  return bus.rst_core;
            SEL_RS:  return bus.rst_sample;
            SEL_RDY: return bus.ready;
            default: return bus.lock_timeout;
        endcase
    endfunction

    // Number of ticks until the selected output equals val; -1 if the budget
    // runs out (which then fails the caller's comparison).
    task automatic wait_for(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while (sig(sel) !== val) begin
            if (n >= budget) begin
                n = -1;
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_areset"}, {31'd0, bus.pll_areset}, 1);
        check({tag, "_rst_core"}, {31'd0, bus.rst_core}, 1);
        check({tag, "_rst_sample"}, {31'd0, bus.rst_sample}, 1);
        check({tag, "_ready"}, {31'd0, bus.ready}, 0);
        check({tag, "_lock_timeout"}, {31'd0, bus.lock_timeout}, 0);
        check({tag, "_cnt"}, {24'd0, bus.lock_loss_cnt}, 0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        losses = 0;
        areset = 1'b0;
    endtask

    task automatic bring_up(input string tag);
        int n;
        do_reset();
        wait_for(SEL_PA, 1'b0, 50, n);
        check({tag, "_pa_len"}, n, PRC);
        bus.pll_locked = 1'b1;
        wait_for(SEL_RDY, 1'b1, 100, n);
        check({tag, "_ready"}, n, SYNC + 1 + LSC + SG);
    endtask

    initial begin
        int n;
        int t;
        int s;
        int d;
        bus.pll_locked = 1'b0;

        // 1: normal bring-up, lock arriving 10 cycles after reset release.
        do_reset();
        timeouts_seen = 0;
        wait_for(SEL_PA, 1'b0, 50, n);
        check("t1_pll_areset_len", n, PRC);
        repeat (10 - PRC) tick();
        bus.pll_locked = 1'b1;
        wait_for(SEL_RC, 1'b0, 100, n);
        check("t1_core_release", n, SYNC + 1 + LSC);
        check("t1_sample_held", {31'd0, bus.rst_sample}, 1);
        wait_for(SEL_RDY, 1'b1, 100, n);
        check("t1_ready", n, SG);
        check("t1_sample_rel", {31'd0, bus.rst_sample}, 0);
        check("t1_cnt", {24'd0, bus.lock_loss_cnt}, exp_cnt());
        check("t1_no_timeout", timeouts_seen, 0);

        // 2: no lock at all -> periodic timeouts and PLL retries.
        do_reset();
        timeouts_seen = 0;
        wait_for(SEL_PA, 1'b0, 50, n);
        check("t2_pll_areset_len", n, PRC);
        wait_for(SEL_LT, 1'b1, 200, n);
        check("t2_first_timeout", n, LTO);
        check("t2_pa_on_timeout", {31'd0, bus.pll_areset}, 1);
        for (int k = 0; k < 3; k++) begin
            wait_for(SEL_PA, 1'b0, 50, n);
            check("t2_retry_pa_len", n, PRC);
            check("t2_pulse_one_cycle", {31'd0, bus.lock_timeout}, 0);
            check("t2_core_held", {31'd0, bus.rst_core}, 1);
            wait_for(SEL_LT, 1'b1, 200, n);
            check("t2_period", n + PRC, LTO + PRC);
        end
        check("t2_timeouts", timeouts_seen, 4);
        check("t2_cnt", {24'd0, bus.lock_loss_cnt}, 0);

        // Randomised lock arrival around the WAIT_LOCK timeout boundary.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            wait_for(SEL_PA, 1'b0, 50, n);
            t = (it < 4) ? (LTO - SYNC - 3 + it) : int'($urandom_range(0, 40));
            timeouts_seen = 0;
            repeat (t) tick();
            bus.pll_locked = 1'b1;
            wait_for(SEL_RC, 1'b0, 200, n);
            check($sformatf("tr_lock_t%0d", t), n, lock_fall_delay(t));
            check($sformatf("tr_timeouts_t%0d", t), timeouts_seen,
                  (t + SYNC + 1 > LTO) ? 1 : 0);
        end

        // 3: one-cycle lock drop in RUN, then full relock.
        bring_up("t3");
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        losses++;
        wait_for(SEL_RC, 1'b1, 20, n);
        check("t3_loss_latency", n, SYNC);
        check("t3_rst_sample", {31'd0, bus.rst_sample}, 1);
        check("t3_ready", {31'd0, bus.ready}, 0);
        check("t3_pll_areset", {31'd0, bus.pll_areset}, 1);
        check("t3_cnt", {24'd0, bus.lock_loss_cnt}, exp_cnt());
        wait_for(SEL_PA, 1'b0, 50, n);
        check("t3_pa_len", n, PRC);
        wait_for(SEL_RC, 1'b0, 100, n);
        check("t3_core_release", n, 1 + LSC);
        wait_for(SEL_RDY, 1'b1, 100, n);
        check("t3_ready_again", n, SG);

        // 4: lock glitch while STABLE -> back to WAIT_LOCK, full stable wait again.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            wait_for(SEL_PA, 1'b0, 50, n);
            bus.pll_locked = 1'b1;
            s = (it == 0) ? 6 : (it == 1) ? LSC : int'($urandom_range(1, LSC));
            pa_seen = 0;
            timeouts_seen = 0;
            repeat (s) tick();
            bus.pll_locked = 1'b0;
            tick();
            bus.pll_locked = 1'b1;
            check($sformatf("t4_core_held_s%0d", s), {31'd0, bus.rst_core}, 1);
            wait_for(SEL_RC, 1'b0, 100, n);
            check($sformatf("t4_relock_s%0d", s), n, SYNC + 1 + LSC);
            check($sformatf("t4_no_pll_rst_s%0d", s), pa_seen, 0);
            check($sformatf("t4_no_timeout_s%0d", s), timeouts_seen, 0);
            check($sformatf("t4_cnt_s%0d", s), {24'd0, bus.lock_loss_cnt}, 0);
        end

        // 5: 260 losses in RUN -> counter saturates (or stays 0 without the option).
        bring_up("t5");
        for (int k = 0; k < 260; k++) begin
            d = int'($urandom_range(1, 2));
            bus.pll_locked = 1'b0;
            repeat (d) tick();
            bus.pll_locked = 1'b1;
            losses++;
            wait_for(SEL_RDY, 1'b0, 20, n);
            check("t5_loss_latency", n, SYNC + 1 - d);
            wait_for(SEL_RDY, 1'b1, 100, n);
            check("t5_relock", n, PRC + 1 + LSC + SG);
            check($sformatf("t5_cnt_%0d", k), {24'd0, bus.lock_loss_cnt}, exp_cnt());
        end

        // 6: areset in the middle of RELEASE aborts immediately.
        wait_for(SEL_RDY, 1'b1, 10, n);
        do_reset();
        wait_for(SEL_PA, 1'b0, 50, n);
        bus.pll_locked = 1'b1;
        wait_for(SEL_RC, 1'b0, 100, n);
        check("t6_core_release", n, SYNC + 1 + LSC);
        tick();
        areset = 1'b1;
        #1;
        check_reset_vals("t6_async");
        losses = 0;
        tick();
        areset = 1'b0;
        wait_for(SEL_PA, 1'b0, 50, n);
        check("t6_pa_len", n, PRC);
        wait_for(SEL_RC, 1'b0, 100, n);
        check("t6_core_release2", n, 1 + LSC);
        wait_for(SEL_RDY, 1'b1, 100, n);
        check("t6_ready", n, SG);
        check("t6_cnt", {24'd0, bus.lock_loss_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
